// File: rtl/scr1_tapc_pkg.sv
// Shared constants and helpers for the TAPC data-register bank: status-bit layout
// of a DR chain and the length-to-mask helper used for every DR.
package scr1_tapc_pkg;

  localparam int unsigned SCR1_TAPC_DR_STAT_W    = 2;
  localparam int unsigned SCR1_TAPC_DR_STAT_VLD  = 0;
  localparam int unsigned SCR1_TAPC_DR_STAT_OVRN = 1;

  // Widest DR the mask helper can describe; callers slice the low bits they need.
  localparam int unsigned SCR1_TAPC_MASK_MAX_W   = 64;

  function automatic logic [SCR1_TAPC_MASK_MAX_W-1:0] scr1_tapc_len_mask(input int unsigned len);
    logic [SCR1_TAPC_MASK_MAX_W-1:0] m;
    m = '0;
    for (int b = 0; b < int'(SCR1_TAPC_MASK_MAX_W); b++) begin
      if (b < int'(len)) begin
        m[b] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/scr1_tapc_dr_hsk.sv
// Per-DR valid/acknowledge tracker with a sticky overrun flag; one instance per DR.
module scr1_tapc_dr_hsk (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_n_sync,
  input  logic upd,
  input  logic ack,
  input  logic cap_clr,
  output logic vld,
  output logic ovrn
);

  logic vld_q;
  logic vld_d;
  logic ovrn_q;
  logic ovrn_d;

  always_comb begin
    vld_d  = vld_q;
    ovrn_d = ovrn_q;
    if (cap_clr) begin
      ovrn_d = 1'b0;
    end
    if (upd) begin
      // An update landing on an unacknowledged shadow loses the older value.
      if (vld_q && !ack) begin
        ovrn_d = 1'b1;
      end
      vld_d = 1'b1;
    end else if (ack && vld_q) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      ovrn_q <= 1'b0;
    end else if (!rst_n_sync) begin
      vld_q  <= 1'b0;
      ovrn_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      ovrn_q <= ovrn_d;
    end
  end

  assign vld  = vld_q;
  assign ovrn = ovrn_q;

endmodule

// File: rtl/scr1_tapc_dr_bank.sv
// Bank of JTAG data registers sharing one shift chain, with per-DR shadows and handshake.
// Define SCR1_TAPC_DR_STATUS_EN to prepend {ovrn, vld} status bits to every DR chain.
module scr1_tapc_dr_bank
  import scr1_tapc_pkg::*;
#(
  parameter  int unsigned               SCR1_DR_NUM                   = 3,
  parameter  int unsigned               SCR1_DR_WIDTH                 = 32,
  parameter  int unsigned               SCR1_DR_LEN [SCR1_DR_NUM]     = '{default: 32},
  parameter  logic [SCR1_DR_WIDTH-1:0]  SCR1_RESET_VALUE              = '0,
  localparam int unsigned               SCR1_DR_SEL_W                 =
    ($clog2(SCR1_DR_NUM) > 1) ? $clog2(SCR1_DR_NUM) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        rst_n_sync,
  input  logic                                        fsm_dr_select,
  input  logic                                        fsm_dr_capture,
  input  logic                                        fsm_dr_shift,
  input  logic                                        fsm_dr_update,
  input  logic [SCR1_DR_SEL_W-1:0]                    dr_sel,
  input  logic                                        din_serial,
  input  logic [SCR1_DR_NUM-1:0][SCR1_DR_WIDTH-1:0]   din_parallel,
  output logic                                        dout_serial,
  output logic [SCR1_DR_NUM-1:0][SCR1_DR_WIDTH-1:0]   dout_parallel,
  output logic [SCR1_DR_NUM-1:0]                      dout_vld,
  input  logic [SCR1_DR_NUM-1:0]                      dout_ack,
  output logic [SCR1_DR_NUM-1:0]                      dout_ovrn
);

`ifdef SCR1_TAPC_DR_STATUS_EN
  localparam int unsigned STAT_W = SCR1_TAPC_DR_STAT_W;
`else
  localparam int unsigned STAT_W = 0;
`endif
  localparam int unsigned SHIFT_W = SCR1_DR_WIDTH + STAT_W;

  logic [SHIFT_W-1:0]                        shift_reg_q;
  logic [SHIFT_W-1:0]                        shift_reg_d;
  logic [SCR1_DR_NUM-1:0][SHIFT_W-1:0]       chain_img;
  logic [SCR1_DR_NUM-1:0][SHIFT_W-1:0]       chain_mask;
  logic [SCR1_DR_NUM-1:0][SCR1_DR_WIDTH-1:0] data_field;
  logic [SCR1_DR_NUM-1:0]                    dr_hit;
  logic [SCR1_DR_NUM-1:0]                    upd;
  logic [SCR1_DR_NUM-1:0]                    cap_clr;
  logic [SHIFT_W-1:0]                        cur_img;
  logic [SHIFT_W-1:0]                        cur_mask;
  logic [SHIFT_W-1:0]                        cur_top;

  for (genvar gi = 0; gi < SCR1_DR_NUM; gi++) begin : g_dr
    localparam logic [SCR1_TAPC_MASK_MAX_W-1:0] LEN_MASK  = scr1_tapc_len_mask(SCR1_DR_LEN[gi]);
    localparam logic [SCR1_DR_WIDTH-1:0]        DATA_MASK = LEN_MASK[SCR1_DR_WIDTH-1:0];

    logic [SCR1_DR_WIDTH-1:0] shadow_q;
    logic [SCR1_DR_WIDTH-1:0] shadow_d;

    assign dr_hit[gi] = (dr_sel == SCR1_DR_SEL_W'(gi));
    assign upd[gi]    = fsm_dr_select & fsm_dr_update & dr_hit[gi];

`ifdef SCR1_TAPC_DR_STATUS_EN
    assign chain_img[gi][SCR1_TAPC_DR_STAT_VLD]  = dout_vld[gi];
    assign chain_img[gi][SCR1_TAPC_DR_STAT_OVRN] = dout_ovrn[gi];
    assign chain_img[gi][SHIFT_W-1:STAT_W]       = din_parallel[gi] & DATA_MASK;
    assign chain_mask[gi]                        = {DATA_MASK, 2'b11};
    assign data_field[gi]                        = shift_reg_q[SHIFT_W-1:STAT_W] & DATA_MASK;
    // Reading the status bits out is what clears the overrun.
    assign cap_clr[gi]                           = fsm_dr_capture & dr_hit[gi];
`else
    assign chain_img[gi]  = din_parallel[gi] & DATA_MASK;
    assign chain_mask[gi] = DATA_MASK;
    assign data_field[gi] = shift_reg_q & DATA_MASK;
    assign cap_clr[gi]    = 1'b0;
`endif

    always_comb begin
      shadow_d = shadow_q;
      if (upd[gi]) begin
        shadow_d = data_field[gi];
      end
    end

    // Shadow loads mid-Update-DR so it is stable before vld rises on the next posedge.
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= SCR1_RESET_VALUE & DATA_MASK;
      end else if (!rst_n_sync) begin
        shadow_q <= SCR1_RESET_VALUE & DATA_MASK;
      end else begin
        shadow_q <= shadow_d;
      end
    end

    assign dout_parallel[gi] = shadow_q;

    scr1_tapc_dr_hsk i_hsk (
      .clk        (clk),
      .rst_n      (rst_n),
      .rst_n_sync (rst_n_sync),
      .upd        (upd[gi]),
      .ack        (dout_ack[gi]),
      .cap_clr    (cap_clr[gi]),
      .vld        (dout_vld[gi]),
      .ovrn       (dout_ovrn[gi])
    );
  end

  always_comb begin
    // Unmatched dr_sel falls through to a 1-bit chain capturing zero.
    cur_img  = '0;
    cur_mask = SHIFT_W'(1);
    for (int i = 0; i < int'(SCR1_DR_NUM); i++) begin
      if (dr_hit[i]) begin
        cur_img  = chain_img[i];
        cur_mask = chain_mask[i];
      end
    end
    cur_top = cur_mask & ~(cur_mask >> 1);

    shift_reg_d = shift_reg_q;
    if (fsm_dr_capture) begin
      shift_reg_d = cur_img;
    end else if (fsm_dr_shift) begin
      shift_reg_d = ((shift_reg_q >> 1) & cur_mask & ~cur_top)
                  | ({SHIFT_W{din_serial}} & cur_top);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg_q <= '0;
    end else if (!rst_n_sync) begin
      shift_reg_q <= '0;
    end else begin
      shift_reg_q <= shift_reg_d;
    end
  end

  assign dout_serial = shift_reg_q[0];

endmodule

// File: tb/tb_scr1_tapc_dr_bank.sv
// Self-checking bench for scr1_tapc_dr_bank: directed sequences, a vector table and
// randomized transactions checked against a queue-based chain model.
module tb_scr1_tapc_dr_bank;

  localparam int NUM = 3;
  localparam int W   = 32;
  localparam int unsigned LEN [NUM] = '{32, 8, 16};
`ifdef SCR1_TAPC_DR_STATUS_EN
  localparam int STAT = 2;
`else
  localparam int STAT = 0;
`endif

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    rst_n_sync = 1'b1;
  logic                    fsm_dr_select = 1'b0;
  logic                    fsm_dr_capture = 1'b0;
  logic                    fsm_dr_shift = 1'b0;
  logic                    fsm_dr_update = 1'b0;
  logic [1:0]              dr_sel = '0;
  logic                    din_serial = 1'b0;
  logic [NUM-1:0][W-1:0]   din_parallel = '0;
  logic                    dout_serial;
  logic [NUM-1:0][W-1:0]   dout_parallel;
  logic [NUM-1:0]          dout_vld;
  logic [NUM-1:0]          dout_ack = '0;
  logic [NUM-1:0]          dout_ovrn;

  always #5 clk = ~clk;

  scr1_tapc_dr_bank #(
    .SCR1_DR_NUM      (NUM),
    .SCR1_DR_WIDTH    (W),
    .SCR1_DR_LEN      (LEN),
    .SCR1_RESET_VALUE ('0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rst_n_sync     (rst_n_sync),
    .fsm_dr_select  (fsm_dr_select),
    .fsm_dr_capture (fsm_dr_capture),
    .fsm_dr_shift   (fsm_dr_shift),
    .fsm_dr_update  (fsm_dr_update),
    .dr_sel         (dr_sel),
    .din_serial     (din_serial),
    .din_parallel   (din_parallel),
    .dout_serial    (dout_serial),
    .dout_parallel  (dout_parallel),
    .dout_vld       (dout_vld),
    .dout_ack       (dout_ack),
    .dout_ovrn      (dout_ovrn)
  );

  int checks = 0;
  int failures = 0;
  int cap_sel = -1;

  // Reference model: shadows, flags and the active chain as a bit queue (front = TDO).
  logic [W-1:0] m_dp [NUM];
  bit           m_vld [NUM];
  bit           m_ovrn [NUM];
  bit           chain_q [$];

  typedef struct {
    int         sel;
    logic [31:0] data;
    logic [2:0] ack;
    int         chk;
    logic [31:0] exp_dp;
    logic [2:0] exp_vld;
    logic [2:0] exp_ovrn;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int clen(input int sel);
    if (sel >= NUM) return 1;
    return int'(LEN[sel]) + STAT;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_dp[i]   = '0;
      m_vld[i]  = 1'b0;
      m_ovrn[i] = 1'b0;
    end
    chain_q.delete();
  endtask

  task automatic do_reset();
    fsm_dr_capture = 1'b0;
    fsm_dr_shift   = 1'b0;
    fsm_dr_update  = 1'b0;
    dout_ack       = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    model_reset();
  endtask

  task automatic do_capture(input int sel);
    dr_sel = sel[1:0];
    cap_sel = sel;
    fsm_dr_select  = 1'b1;
    fsm_dr_capture = 1'b1;
    tick();
    fsm_dr_capture = 1'b0;
  endtask

  task automatic do_shift(input int n, input logic [63:0] val, output logic [63:0] tdo);
    tdo = '0;
    fsm_dr_shift = 1'b1;
    for (int k = 0; k < n; k++) begin
      din_serial = val[k];
      tdo[k] = dout_serial;
      tick();
    end
    fsm_dr_shift = 1'b0;
  endtask

  task automatic do_update(input logic [2:0] ack);
    assert (int'(dr_sel) == cap_sel) else $error("dr_sel changed between capture and update");
    dout_ack = ack;
    fsm_dr_update = 1'b1;
    tick();
    fsm_dr_update = 1'b0;
    dout_ack = '0;
  endtask

  task automatic do_txn(input int sel, input logic [31:0] data, input logic [2:0] ack);
    logic [63:0] tdo;
    do_capture(sel);
    do_shift(clen(sel), 64'(data) << STAT, tdo);
    do_update(ack);
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic [31:0] e2, input logic [2:0] ev, input logic [2:0] eo);
    check({tag, " dp0"},  64'(dout_parallel[0]), 64'(e0));
    check({tag, " dp1"},  64'(dout_parallel[1]), 64'(e1));
    check({tag, " dp2"},  64'(dout_parallel[2]), 64'(e2));
    check({tag, " vld"},  64'(dout_vld), 64'(ev));
    check({tag, " ovrn"}, 64'(dout_ovrn), 64'(eo));
  endtask

  // One clock of the model (negedge shadow write, then posedge rules), then the real clock.
  task automatic step();
    int sel;
    bit ok;
    bit u;
    sel = int'(dr_sel);
    ok  = sel < NUM;
    if (fsm_dr_select && fsm_dr_update && ok) begin
      m_dp[sel] = '0;
      for (int b = 0; b < int'(LEN[sel]); b++) m_dp[sel][b] = chain_q[b + STAT];
    end
    if (fsm_dr_capture) begin
      chain_q.delete();
      if (!ok) begin
        chain_q.push_back(1'b0);
      end else begin
        if (STAT == 2) begin
          chain_q.push_back(m_vld[sel]);
          chain_q.push_back(m_ovrn[sel]);
        end
        for (int b = 0; b < int'(LEN[sel]); b++) chain_q.push_back(din_parallel[sel][b]);
      end
    end else if (fsm_dr_shift && chain_q.size() > 0) begin
      void'(chain_q.pop_front());
      chain_q.push_back(din_serial);
    end
    for (int i = 0; i < NUM; i++) begin
      u = fsm_dr_select && fsm_dr_update && (sel == i);
      if (STAT == 2 && fsm_dr_capture && sel == i) m_ovrn[i] = 1'b0;
      if (u) begin
        if (m_vld[i] && !dout_ack[i]) m_ovrn[i] = 1'b1;
        m_vld[i] = 1'b1;
      end else if (dout_ack[i] && m_vld[i]) begin
        m_vld[i] = 1'b0;
      end
    end
    tick();
  endtask

  initial begin : main
    logic [63:0] tdo;
    int sel, n, idle;

    vecs[0] = '{1, 32'h0000003C, 3'b000, 1, 32'h0000003C, 3'b010, 3'b000};
    vecs[1] = '{1, 32'h000001FF, 3'b000, 1, 32'h000000FF, 3'b010, 3'b010};
    vecs[2] = '{2, 32'h00001234, 3'b000, 2, 32'h00001234, 3'b110, 3'b010};
    vecs[3] = '{2, 32'h0000BEEF, 3'b100, 2, 32'h0000BEEF, 3'b110, 3'b010};
    vecs[4] = '{0, 32'hDEADBEEF, 3'b011, 0, 32'hDEADBEEF, 3'b101, 3'b010};
    vecs[5] = '{3, 32'h00000001, 3'b000, 2, 32'h0000BEEF, 3'b101, 3'b010};
    vecs[6] = '{0, 32'h00000000, 3'b000, 0, 32'h00000000, 3'b101, 3'b011};

    // Reset state
    #12;
    rst_n = 1'b1;
    tick();
    check_outs("rst", 0, 0, 0, 3'b000, 3'b000);
    check("rst tdo", 64'(dout_serial), 64'd0);

    // Capture 0xA5 on DR1, shift in 0x3C, update
    din_parallel[0] = 32'h11111111;
    din_parallel[1] = 32'h000000A5;
    din_parallel[2] = 32'h22222222;
    do_capture(1);
    do_shift(8 + STAT, 64'h3C << STAT, tdo);
    check("cap tdo", tdo, 64'hA5 << STAT);
    fsm_dr_update = 1'b1;
    @(negedge clk);
    #1;
    check("upd dp1 negedge", 64'(dout_parallel[1]), 64'h3C);
    check("upd vld negedge", 64'(dout_vld), 64'd0);
    @(posedge clk);
    #1;
    fsm_dr_update = 1'b0;
    check_outs("upd", 0, 32'h3C, 0, 3'b010, 3'b000);

    // Ack clears vld; stray ack is ignored
    dout_ack = 3'b010;
    tick();
    dout_ack = 3'b000;
    check("ack vld", 64'(dout_vld), 64'd0);
    dout_ack = 3'b010;
    tick();
    dout_ack = 3'b000;
    check_outs("ack idle", 0, 32'h3C, 0, 3'b000, 3'b000);

    // Synchronous reset while shifting
    do_txn(1, 32'h77, 3'b000);
    do_capture(1);
    fsm_dr_shift = 1'b1;
    din_serial = 1'b1;
    tick();
    tick();
    rst_n_sync = 1'b0;
    tick();
    rst_n_sync = 1'b1;
    fsm_dr_shift = 1'b0;
    check_outs("srst", 0, 0, 0, 3'b000, 3'b000);
    check("srst tdo", 64'(dout_serial), 64'd0);

    // Overrun on DR2, then the same with ack on the second update
    do_reset();
    do_txn(2, 32'h1234, 3'b000);
    do_txn(2, 32'hBEEF, 3'b000);
    check_outs("ovrn", 0, 0, 32'hBEEF, 3'b100, 3'b100);
    do_reset();
    do_txn(2, 32'h1234, 3'b000);
    do_txn(2, 32'hBEEF, 3'b100);
    check_outs("ovrn ack", 0, 0, 32'hBEEF, 3'b100, 3'b000);

    // Out-of-range select: 1-bit path, update ignored
    do_capture(3);
    do_shift(3, 64'b101, tdo);
    check("oor tdo", tdo, 64'b010);
    check("oor last", 64'(dout_serial), 64'd1);
    do_update(3'b000);
    check_outs("oor upd", 0, 0, 32'hBEEF, 3'b100, 3'b000);

`ifdef SCR1_TAPC_DR_STATUS_EN
    // Status bits lead the chain and capture clears overrun
    do_reset();
    do_txn(1, 32'h01, 3'b000);
    do_txn(1, 32'h02, 3'b000);
    check("st pre ovrn", 64'(dout_ovrn), 64'b010);
    din_parallel[1] = 32'hA5;
    do_capture(1);
    check("st cap ovrn", 64'(dout_ovrn), 64'd0);
    do_shift(10, 64'd0, tdo);
    check("st tdo", tdo, (64'hA5 << 2) | 64'd3);
`endif

    // Vector table
    do_reset();
    for (int v = 0; v < 7; v++) begin
      do_txn(vecs[v].sel, vecs[v].data, vecs[v].ack);
      check($sformatf("vec%0d dp", v), 64'(dout_parallel[vecs[v].chk]), 64'(vecs[v].exp_dp));
      check($sformatf("vec%0d vld", v), 64'(dout_vld), 64'(vecs[v].exp_vld));
      check($sformatf("vec%0d ovrn", v), 64'(dout_ovrn), 64'(vecs[v].exp_ovrn));
      $display("vec %0d sel=%0d data=%0h vld=%b ovrn=%b", v, vecs[v].sel, vecs[v].data, dout_vld, dout_ovrn);
    end

    // Randomized transactions against the model
    do_reset();
    for (int t = 0; t < 100; t++) begin
      sel = $urandom_range(0, 3);
      for (int i = 0; i < NUM; i++) din_parallel[i] = $urandom();
      dr_sel = sel[1:0];
      fsm_dr_select = 1'b1;
      fsm_dr_capture = 1'b1;
      step();
      fsm_dr_capture = 1'b0;
      n = $urandom_range(0, clen(sel) + 2);
      fsm_dr_shift = 1'b1;
      for (int k = 0; k < n; k++) begin
        din_serial = 1'($urandom_range(0, 1));
        check("rnd tdo", 64'(dout_serial), 64'(chain_q.size() > 0 ? chain_q[0] : 1'b0));
        step();
      end
      fsm_dr_shift = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        fsm_dr_update = 1'b1;
        dout_ack = 3'($urandom_range(0, 7));
        step();
        fsm_dr_update = 1'b0;
      end
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        dout_ack = 3'($urandom_range(0, 7));
        step();
      end
      dout_ack = '0;
      for (int i = 0; i < NUM; i++) begin
        check($sformatf("rnd dp%0d", i), 64'(dout_parallel[i]), 64'(m_dp[i]));
        check($sformatf("rnd vld%0d", i), 64'(dout_vld[i]), 64'(m_vld[i]));
        check($sformatf("rnd ovrn%0d", i), 64'(dout_ovrn[i]), 64'(m_ovrn[i]));
      end
      $display("txn %0d sel=%0d shifts=%0d vld=%b ovrn=%b", t, sel, n, dout_vld, dout_ovrn);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
